// File: rtl/fft_pkg.sv
// Shared FFT-stage constants and helpers.
//   N         : sample width (two's-complement)
//   CNT_W     : frame-counter width, frame length = 2^CNT_W samples
//   FRAME_LEN : samples per frame
//   sext()    : sign-extend an N-bit sample onto N+1 bits
package fft_pkg;

    localparam int unsigned N         = 8;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned FRAME_LEN = 1 << CNT_W;

    // Sign-extend one sample by one bit so sum/difference cannot overflow.
    function automatic logic signed [N:0] sext(input logic signed [N-1:0] v);
        return {v[N-1], v};
    endfunction

endpackage

// File: rtl/fft_seq_cnt.sv
// Per-frame sample counter for one FFT stage.
// Ports:
//   clk, clear     : clock, synchronous active-high reset
//   in_valid       : advance the counter this cycle (holds otherwise)
//   s0, s1         : commutator selects, decoded from the registered count
//   frame_done     : registered pulse the cycle after the last sample of a frame
module fft_seq_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic in_valid,
    output logic s0,
    output logic s1,
    output logic frame_done
);

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    assign cnt_last = (cnt == {CNT_W{1'b1}});

    // Wrapping counter; natural overflow gives the 2^CNT_W-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_valid & cnt_last;
            if (in_valid) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Selects come straight from the register, never from in_valid.
    assign s0 = cnt[CNT_W-1];
    assign s1 = cnt[CNT_W-2];

endmodule

// File: rtl/fft_bf_ctrl.sv
// Radix-2 butterfly and commutator sequencer for one pipelined FFT stage.
// Ports:
//   clk, clear  : clock, synchronous active-high reset
//   in_valid    : qualifies x and y
//   x           : new input sample (also routed to the commutator)
//   y           : delayed sample returned by the commutator
//   s0, s1      : commutator selects
//   out_valid   : sum/diff valid
//   sum, diff   : registered y+x and y-x on N+1 bits
//   frame_done  : one-cycle pulse after the last sample of a frame
// Build option: define BF_SCALE_EN to halve both outputs (arithmetic shift),
// keeping magnitudes within N bits across cascaded stages.
module fft_bf_ctrl
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                in_valid,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] y,
    output logic                s0,
    output logic                s1,
    output logic                out_valid,
    output logic signed [N:0]   sum,
    output logic signed [N:0]   diff,
    output logic                frame_done
);

    logic               bf_issue;
    logic signed [N:0]  sum_full;
    logic signed [N:0]  diff_full;
    logic signed [N:0]  sum_c;
    logic signed [N:0]  diff_c;

    fft_seq_cnt #(
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk        (clk),
        .clear      (clear),
        .in_valid   (in_valid),
        .s0         (s0),
        .s1         (s1),
        .frame_done (frame_done)
    );

    // Butterfly only on the second half of the frame.
    assign bf_issue = in_valid & s0;

    // Full-growth butterfly; one extra bit makes overflow impossible.
    assign sum_full  = sext(y) + sext(x);
    assign diff_full = sext(y) - sext(x);

`ifdef BF_SCALE_EN
    // Floor-halving; the arithmetic shift keeps the sign on the N+1-bit port.
    assign sum_c  = sum_full  >>> 1;
    assign diff_c = diff_full >>> 1;
`else
    assign sum_c  = sum_full;
    assign diff_c = diff_full;
`endif

    // Output registers; sum/diff hold whenever the butterfly does not issue.
    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid <= 1'b0;
            sum       <= '0;
            diff      <= '0;
        end else begin
            out_valid <= bf_issue;
            if (bf_issue) begin
                sum  <= sum_c;
                diff <= diff_c;
            end
        end
    end

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Self-checking bench for fft_bf_ctrl: randomized and directed frames against
// a sample-index reference model, butterfly results checked via a scoreboard.
module tb_fft_bf_ctrl;
    import fft_pkg::*;

    logic                clk;
    logic                clear;
    logic                in_valid;
    logic signed [N-1:0] x;
    logic signed [N-1:0] y;
    logic                s0;
    logic                s1;
    logic                out_valid;
    logic signed [N:0]   sum;
    logic signed [N:0]   diff;
    logic                frame_done;

    fft_bf_ctrl dut (
        .clk        (clk),
        .clear      (clear),
        .in_valid   (in_valid),
        .x          (x),
        .y          (y),
        .s0         (s0),
        .s1         (s1),
        .out_valid  (out_valid),
        .sum        (sum),
        .diff       (diff),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int diff;
        bit last;
    } bf_t;

    bf_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: position of the next sample within its frame.
    int idx    = 0;
    int m_sum  = 0;
    int m_diff = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
    endfunction

    // One clock: drive at negedge, update the model at the following posedge.
    task automatic cyc(input bit clr, input bit v, input int xv, input int yv);
        int s;
        int d;
        bf_t item;
        @(negedge clk);
        clear    = clr;
        in_valid = v;
        x        = N'(xv);
        y        = N'(yv);
        @(posedge clk);
        if (clr) begin
            idx    = 0;
            m_sum  = 0;
            m_diff = 0;
        end else if (v) begin
            if (idx >= int'(FRAME_LEN / 2)) begin
                s = yv + xv;
                d = yv - xv;
`ifdef BF_SCALE_EN
                s = s >>> 1;
                d = d >>> 1;
`endif
                item.sum  = s;
                item.diff = d;
                item.last = (idx == int'(FRAME_LEN) - 1);
                q.push_back(item);
                m_sum  = s;
                m_diff = d;
            end
            idx = (idx + 1) % int'(FRAME_LEN);
        end
    endtask

    task automatic frame_rand();
        for (int i = 0; i < int'(FRAME_LEN); i++) cyc(1'b0, 1'b1, rnd_sample(), rnd_sample());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rnd_sample(), rnd_sample());
    endtask

    // Monitor: selects every cycle, scoreboard pop on out_valid, hold otherwise.
    initial begin
        bf_t item;
        @(posedge clk);
        forever begin
            #2;
            chk("s0", int'(s0), int'(idx >= int'(FRAME_LEN / 2)));
            chk("s1", int'(s1), (idx / int'(FRAME_LEN / 4)) % 2);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    item = q.pop_front();
                    chk("sum", int'(sum), item.sum);
                    chk("diff", int'(diff), item.diff);
                    chk("frame_done", int'(frame_done), int'(item.last));
                end
            end else begin
                chk("frame_done_idle", int'(frame_done), 0);
                chk("sum_hold", int'(sum), m_sum);
                chk("diff_hold", int'(diff), m_diff);
            end
            @(posedge clk);
        end
    end

    initial begin
        clear    = 1'b1;
        in_valid = 1'b1;
        x        = '0;
        y        = '0;

        // Reset held two cycles with in_valid high.
        cyc(1'b1, 1'b1, rnd_sample(), rnd_sample());
        cyc(1'b1, 1'b1, rnd_sample(), rnd_sample());

        // Plain random frame.
        frame_rand();

        // Extreme operands on the butterfly half.
        for (int i = 0; i < int'(FRAME_LEN / 2); i++) cyc(1'b0, 1'b1, rnd_sample(), rnd_sample());
        cyc(1'b0, 1'b1,  127,  127);
        cyc(1'b0, 1'b1,  127, -128);
        cyc(1'b0, 1'b1, -128, -128);
        cyc(1'b0, 1'b1, -128,  127);

        // Three-cycle gap at the boundary, then a resumed frame.
        idle(3);
        frame_rand();

        // Clear at sample 5 abandons the frame; next frame starts fresh.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, rnd_sample(), rnd_sample());
        cyc(1'b1, 1'b1, rnd_sample(), rnd_sample());
        frame_rand();

        // Random frames with boundary gaps and occasional mid-frame clears.
        for (int f = 0; f < 40; f++) begin
            int clr_at;
            idle(int'($urandom_range(0, 2)));
            clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1;
            for (int i = 0; i < int'(FRAME_LEN); i++) begin
                if (i == clr_at) begin
                    cyc(1'b1, $urandom_range(0, 1) == 1, rnd_sample(), rnd_sample());
                    break;
                end
                cyc(1'b0, 1'b1, rnd_sample(), rnd_sample());
            end
        end

        idle(3);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
